register_file_mp: RTL

- Parametrised multi-port register file: NRD read ports, NWR write ports, configurable width and depth.
- Adds optional same-cycle write-to-read bypass and a per-register busy scoreboard, set by an allocate port and cleared by writeback.
- Serves the pipelined datapath: decode reads operands and reserves destinations, writeback clears the reservations.
- Operand stall logic uses rbusy directly.

---
 rtl/register_file_mp.sv | 91 +++++++++
 1 files changed

// File: rtl/register_file_mp.sv
// Multi-port register file with optional same-cycle write bypass and a
// per-register busy scoreboard (allocate sets, writeback clears, flush clears all).
module register_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic [NWR-1:0]                    wen,
  input  logic [NWR*$clog2(NREGS)-1:0]      wsel,
  input  logic [NWR*DATA_W-1:0]             wdat,
  input  logic [NRD*$clog2(NREGS)-1:0]      rsel,
  output logic [NRD*DATA_W-1:0]             rdat,
  output logic [NRD-1:0]                    rbusy,
  input  logic                              alloc_en,
  input  logic [$clog2(NREGS)-1:0]          alloc_sel,
  input  logic                              flush,
  output logic [NREGS-1:0]                  busy
);

  localparam int unsigned AW  = $clog2(NREGS);
  localparam int unsigned RLO = (ZERO_REG != 0) ? 1 : 0;
  localparam bit          BYP = (BYPASS != 0);

  logic [NREGS-1:0][DATA_W-1:0] r_regs;
  logic [NREGS-1:0]             r_busy;
  logic [NREGS-1:0]             w_hit;
  logic [NREGS-1:0][DATA_W-1:0] w_wdata;
  logic [NREGS-1:0]             w_busy_nxt;

  // Per-register write resolution; indices outside [RLO, NREGS) never match,
  // and the ascending port loop lets the highest-numbered port win.
  always_comb begin
    w_hit   = '0;
    w_wdata = '0;
    for (int unsigned r = RLO; r < NREGS; r++) begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (wen[k] && (wsel[k*AW +: AW] == AW'(r))) begin
          w_hit[r]   = 1'b1;
          w_wdata[r] = wdat[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_regs <= '0;
    end else begin
      for (int unsigned r = RLO; r < NREGS; r++) begin
        if (w_hit[r]) r_regs[r] <= w_wdata[r];
      end
    end
  end

  // Allocate outranks a same-cycle writeback: the allocation is the newer producer.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned r = RLO; r < NREGS; r++) begin
      if (flush)                                       w_busy_nxt[r] = 1'b0;
      else if (alloc_en && (alloc_sel == AW'(r)))      w_busy_nxt[r] = 1'b1;
      else if (w_hit[r])                               w_busy_nxt[r] = 1'b0;
    end
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  always_comb begin
    rdat  = '0;
    rbusy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      for (int unsigned r = RLO; r < NREGS; r++) begin
        if (nRST && (rsel[i*AW +: AW] == AW'(r))) begin
          rdat[i*DATA_W +: DATA_W] = (BYP && w_hit[r]) ? w_wdata[r] : r_regs[r];
          rbusy[i]                 = r_busy[r] && !(BYP && w_hit[r]);
        end
      end
    end
  end

  assign busy = r_busy;

endmodule
